// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the RISC-V fetch pipeline.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  // Fetch sequencer states, one request outstanding at most.
  typedef enum logic [1:0] {
    REQ  = 2'd0,   // presenting a request to instruction memory
    WAIT = 2'd1,   // request accepted, waiting for its response
    HOLD = 2'd2,   // response parked in the skid buffer behind a decode stall
    DROP = 2'd3    // waiting for a stale response to discard after a redirect
  } fetch_state_t;

  // addi x0, x0, 0 - the canonical bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential-PC helper; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
//------------------------------------------------------------------------------
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register with flush > stall > load > bubble
//            update priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifid_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d
);

  // Pipeline register update; a flush leaves pc fields untouched so they stay deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP_INSTR;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
    end else if (flush) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP_INSTR;
    end else if (stall) begin
      valid_d   <= valid_d;
    end else if (load) begin
      valid_d   <= 1'b1;
      instr_d   <= instr;
      pc_d      <= pc;
      pcplus4_d <= pc_plus4(pc);
    end else begin
      valid_d   <= 1'b0;
      instr_d   <= NOP_INSTR;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : fetch_stage
// Purpose  : Instruction fetch: PC, single-outstanding memory request
//            sequencer, skid buffer for stalled responses and the IF/ID
//            register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        redirect_e,
  input  logic [31:0] pctarget_e,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d
);

  fetch_state_t state, state_n;
  logic [31:0]  pc_f, pc_f_n;
  logic [31:0]  pc_req;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  logic         req_accept;
  logic         skid_capture;
  logic         ifid_load;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;

  // A redirect suppresses the request in the same cycle so a wrong-path
  // address is never accepted; reset keeps the bus quiet.
  assign imem_req_valid = (state == REQ) && !redirect_e && !reset;
  assign imem_req_addr  = pc_f;
  assign req_accept     = imem_req_valid && imem_req_ready;

  // Next-state, next-PC and IF/ID load selection; redirect dominates everywhere.
  always_comb begin
    state_n      = state;
    pc_f_n       = pc_f;
    skid_capture = 1'b0;
    ifid_load    = 1'b0;
    ifid_instr   = skid_instr;
    ifid_pc      = skid_pc;
    case (state)
      REQ: begin
        if (redirect_e) begin
          pc_f_n = pctarget_e;
        end else if (req_accept) begin
          pc_f_n  = pc_plus4(pc_f);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_e) begin
          pc_f_n  = pctarget_e;
          state_n = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          if (stall_d) begin
            skid_capture = 1'b1;
            state_n      = HOLD;
          end else begin
            ifid_load  = 1'b1;
            ifid_instr = imem_rsp_data;
            ifid_pc    = pc_req;
            state_n    = REQ;
          end
        end
      end
      HOLD: begin
        if (redirect_e) begin
          pc_f_n  = pctarget_e;
          state_n = REQ;
        end else if (!stall_d) begin
          ifid_load = 1'b1;
          state_n   = REQ;
        end
      end
      DROP: begin
        if (redirect_e) begin
          pc_f_n = pctarget_e;
        end
        if (imem_rsp_valid) begin
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  // Sequencer state, fetch PC, outstanding-request PC and skid buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      pc_f       <= RESET_PC;
      pc_req     <= 32'd0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'd0;
    end else begin
      state <= state_n;
      pc_f  <= pc_f_n;
      if (req_accept) begin
        pc_req <= pc_f;
      end
      if (skid_capture) begin
        skid_instr <= imem_rsp_data;
        skid_pc    <= pc_req;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (ifid_load),
    .flush     (redirect_e),
    .stall     (stall_d),
    .instr     (ifid_instr),
    .pc        (ifid_pc),
    .valid_d   (valid_d),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pcplus4_d (pcplus4_d)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with a latency-configurable
//            instruction memory model and an in-order retire scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_d = 1'b0;
  logic        redirect_e = 1'b0;
  logic [31:0] pctarget_e = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb[$];      // expected retire stream: {pc, instr}
  logic [31:0] acc_q[$];   // addresses accepted by the memory model

  logic        mem_ready = 1'b0;
  int          mem_lat = 1;
  logic        busy;
  int          cnt;
  logic [31:0] addr_q;
  int          rsp_cnt = 0;

  assign imem_req_ready = mem_ready;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_d        (stall_d),
    .redirect_e     (redirect_e),
    .pctarget_e     (pctarget_e),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pcplus4_d      (pcplus4_d)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0003;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Memory model: one request at a time, response mem_lat cycles after accept.
  always @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      cnt            <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'd0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= mem_word(addr_q);
          busy           <= 1'b0;
          rsp_cnt        <= rsp_cnt + 1;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req_valid && mem_ready) begin
        busy   <= 1'b1;
        cnt    <= mem_lat - 1;
        addr_q <= imem_req_addr;
        acc_q.push_back(imem_req_addr);
      end
    end
  end

  // Retire monitor: decode consumes IF/ID when it is valid and not stalled.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset === 1'b0 && valid_d === 1'b1 && stall_d === 1'b0) begin
      if (sb.size() == 0) begin
        check_eq("extra_retire", {31'b0, valid_d}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ret_pc", pc_d, e[63:32]);
        check_eq("ret_instr", instr_d, e[31:0]);
        check_eq("ret_pcplus4", pcplus4_d, e[63:32] + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input bit push);
    if (push) sb.push_back({a, mem_word(a)});
    mem_ready = 1'b1;
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) tick();
    mem_ready = 1'b0;
    if (acc_q.size() == 0) check_eq("accept_timeout", acc_q.size(), 32'd1);
    else check_eq("req_addr", acc_q.pop_front(), a);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    repeat (3) tick();
    check_eq("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int rsp_before;
    // Reset values
    repeat (3) tick();
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_valid_d", {31'b0, valid_d}, 32'd0);
    check_eq("rst_instr_d", instr_d, NOP);
    check_eq("rst_pc_d", pc_d, 32'd0);
    check_eq("rst_pcplus4_d", pcplus4_d, 32'd0);
    reset = 1'b0;
    tick();

    // Sequential fetch 0x0/0x4/0x8
    mem_lat = 1;
    issue(32'h0, 1'b1);
    issue(32'h4, 1'b1);
    issue(32'h8, 1'b1);
    drain();

    // Memory not ready: request and address held
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check_eq("hold_req_addr", imem_req_addr, 32'hC);
    end
    issue(32'hC, 1'b1);
    drain();

    // Response lands under a decode stall and is parked
    rsp_before = rsp_cnt;
    issue(32'h10, 1'b1);
    stall_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("stall_valid_d", {31'b0, valid_d}, 32'd0);
      check_eq("stall_instr_d", instr_d, NOP);
    end
    check_eq("stall_rsp_seen", rsp_cnt, rsp_before + 1);
    stall_d = 1'b0;
    drain();

    // Redirect while waiting with no response: stale word dropped
    mem_lat = 3;
    issue(32'h14, 1'b0);
    tick();
    redirect_e = 1'b1;
    pctarget_e = 32'h100;
    #1;
    check_eq("redir_req_gated", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_e = 1'b0;
    check_eq("flush_valid_d", {31'b0, valid_d}, 32'd0);
    check_eq("flush_instr_d", instr_d, NOP);
    issue(32'h100, 1'b1);
    drain();

    // Redirect coincident with response and stall
    mem_lat = 1;
    issue(32'h104, 1'b0);
    tick();
    check_eq("rsp_coincide", {31'b0, imem_rsp_valid}, 32'd1);
    redirect_e = 1'b1;
    stall_d    = 1'b1;
    pctarget_e = 32'h200;
    tick();
    redirect_e = 1'b0;
    stall_d    = 1'b0;
    check_eq("coinc_valid_d", {31'b0, valid_d}, 32'd0);
    check_eq("coinc_instr_d", instr_d, NOP);
    issue(32'h200, 1'b1);
    drain();

    // Reset asserted mid-WAIT
    mem_lat = 3;
    issue(32'h204, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    check_eq("mid_rst_valid_d", {31'b0, valid_d}, 32'd0);
    check_eq("mid_rst_instr_d", instr_d, NOP);
    check_eq("mid_rst_pc_d", pc_d, 32'd0);
    reset = 1'b0;
    issue(32'h0, 1'b1);
    drain();

    check_eq("acc_q_empty", acc_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
